fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter PC_RESET, default 16'h0000, meaning program counter value after reset.
REQ-002 SHALL have ports clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have clr  input  1  reset, synchronous and active-high.
REQ-004 SHALL have run  input  1  start/continue sequencing; sampled in IDLE only.
REQ-005 SHALL have instruction  input  16  program-memory word driven while ld_inst is high.
REQ-006 SHALL have addbus  input  16  jump target driven by program memory while ld_val_reg=5.
REQ-007 SHALL have jump_cond  input  1  flag from ALU/flag word; sampled in EXEC of JC.
REQ-008 SHALL have pc  output  16  program-memory word address.
REQ-009 SHALL have ld_inst  output  1  program-memory output enable.
REQ-010 SHALL have ld_val_reg  output  3  program-memory field select: 0 val, 1 reg1, 2 reg2, 3 reg3, 5 address.
REQ-011 SHALL have dm_rd, dm_rd_latch, dm_wr, alu_write  output  1 each  data-memory/ALU strobes.
REQ-012 SHALL have halted, illegal  output  1 each  status flags.

Function
REQ-013 SHALL implement states IDLE, FETCH, DECODE, EXEC1, EXEC2, HALT, one state per cycle.
REQ-014 SHALL go IDLE->FETCH when run=1, else stay IDLE; pc held.
REQ-015 SHALL in FETCH drive pc only, all strobes 0; next DECODE.
REQ-016 SHALL in DECODE drive ld_inst=1, ld_val_reg=0, capture opcode=instruction[15:13] into IR; next EXEC1.
REQ-017 SHALL hold ld_inst=1 in EXEC1/EXEC2; in FETCH, IDLE, HALT ld_inst=0 and ld_val_reg=0.
REQ-018 SHALL decode IR: 000 NOP, 001 LDI, 010 MOV, 011 ALU, 100 JMP, 101 JC, 110 HLT, 111 illegal.
REQ-019 NOP: EXEC1 no strobes; pc+1; ->FETCH.
REQ-020 LDI: EXEC1 ld_val_reg=0, dm_wr=1; pc+1; ->FETCH.
REQ-021 MOV: EXEC1 ld_val_reg=1, dm_rd=1, dm_rd_latch=1; EXEC2 ld_val_reg=2, dm_wr=1; pc+1; ->FETCH.
REQ-022 ALU: EXEC1 ld_val_reg=3, dm_rd=1; EXEC2 ld_val_reg=3, alu_write=1; pc+1; ->FETCH.
REQ-023 JMP (two-word): EXEC1 pc<=pc+1 (no strobes); EXEC2 ld_val_reg=5, pc<=addbus; ->FETCH.
REQ-024 JC: as JMP, but EXEC2 loads addbus only if jump_cond sampled in EXEC1 was 1; else pc<=pc+1 (skips address word).
REQ-025 HLT: EXEC1 ->HALT, pc unchanged, halted=1; HALT exits only by clr.
REQ-026 Illegal (111): illegal=1 (sticky until clr), treated as NOP.
REQ-027 SHALL assert at most one of dm_rd-group, dm_wr, alu_write per cycle; each strobe one cycle wide.
REQ-028 SHALL update pc only in EXEC1/EXEC2 as stated; increment modulo 2^16 (16'hFFFF+1 = 16'h0000).
REQ-029 SHALL ignore run outside IDLE; deasserting run mid-instruction does not abort it.
REQ-030 SHALL return to FETCH (not IDLE) after every instruction except HLT.

Reset
REQ-031 clr=1 at a rising edge SHALL force state IDLE, pc=PC_RESET, IR=000, halted=0, illegal=0, all strobes 0, ld_val_reg=0, in any state including mid-instruction.
REQ-032 clr SHALL take priority over run and every transition; outputs valid reset values the cycle after clr sampled.

Verification
REQ-033 Reset mid-MOV (clr in EXEC1) -> next cycle pc=16'h0000, state IDLE, dm_wr never pulses.
REQ-034 run=1, PM: 0x2000 (LDI) at 0 -> cycles FETCH,DECODE,EXEC1 with dm_wr=1, ld_val_reg=0; pc=1 after.
REQ-035 MOV at pc=4 -> EXEC1 ld_val_reg=1 dm_rd=dm_rd_latch=1, EXEC2 ld_val_reg=2 dm_wr=1; pc=5.
REQ-036 JC at pc=8, addbus=16'h0040: jump_cond=1 -> pc=16'h0040; jump_cond=0 -> pc=10.
REQ-037 JMP at pc=16'hFFFF, addbus=16'h0003 -> EXEC1 pc wraps to 0, EXEC2 pc=3.
REQ-038 Opcode 111 then HLT -> illegal=1 held, halted=1, pc frozen, run toggling no effect until clr.

Source files
------------

// File: rtl/fetch_seq.sv
// Instruction fetch/sequencing controller: walks FETCH/DECODE/EXEC phases and
// drives program-memory field selects plus data-memory/ALU strobes.
module fetch_seq #(
   parameter logic [15:0] PC_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic [15:0] instruction,
   input  logic [15:0] addbus,
   input  logic        jump_cond,
   output logic [15:0] pc,
   output logic        ld_inst,
   output logic [2:0]  ld_val_reg,
   output logic        dm_rd,
   output logic        dm_rd_latch,
   output logic        dm_wr,
   output logic        alu_write,
   output logic        halted,
   output logic        illegal
);

   localparam int unsigned PC_W  = 16;
   localparam int unsigned OP_W  = 3;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned ST_W  = 3;

   localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
   localparam logic [ST_W-1:0] S_FETCH  = 3'd1;
   localparam logic [ST_W-1:0] S_DECODE = 3'd2;
   localparam logic [ST_W-1:0] S_EXEC1  = 3'd3;
   localparam logic [ST_W-1:0] S_EXEC2  = 3'd4;
   localparam logic [ST_W-1:0] S_HALT   = 3'd5;

   localparam logic [OP_W-1:0] OP_NOP = 3'b000;
   localparam logic [OP_W-1:0] OP_LDI = 3'b001;
   localparam logic [OP_W-1:0] OP_MOV = 3'b010;
   localparam logic [OP_W-1:0] OP_ALU = 3'b011;
   localparam logic [OP_W-1:0] OP_JMP = 3'b100;
   localparam logic [OP_W-1:0] OP_JC  = 3'b101;
   localparam logic [OP_W-1:0] OP_HLT = 3'b110;
   localparam logic [OP_W-1:0] OP_ILL = 3'b111;

   localparam logic [SEL_W-1:0] SEL_VAL  = 3'd0;
   localparam logic [SEL_W-1:0] SEL_REG1 = 3'd1;
   localparam logic [SEL_W-1:0] SEL_REG2 = 3'd2;
   localparam logic [SEL_W-1:0] SEL_REG3 = 3'd3;
   localparam logic [SEL_W-1:0] SEL_ADDR = 3'd5;

   logic [ST_W-1:0]  state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [OP_W-1:0]  ir_q, ir_d;
   logic             jc_q, jc_d;
   logic             halted_q, halted_d;
   logic             illegal_q, illegal_d;
   logic             ld_inst_q, ld_inst_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             dm_rd_q, dm_rd_d;
   logic             dm_rd_latch_q, dm_rd_latch_d;
   logic             dm_wr_q, dm_wr_d;
   logic             alu_write_q, alu_write_d;
   logic [PC_W-1:0]  pc_inc;

   // Only the opcode field is decoded here; the rest belongs to the datapath.
   logic             instr_unused;
   assign instr_unused = ^instruction[12:0];

   assign pc_inc = pc_q + PC_W'(1);

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q       <= S_IDLE;
         pc_q          <= PC_RESET;
         ir_q          <= OP_NOP;
         jc_q          <= 1'b0;
         halted_q      <= 1'b0;
         illegal_q     <= 1'b0;
         ld_inst_q     <= 1'b0;
         sel_q         <= SEL_VAL;
         dm_rd_q       <= 1'b0;
         dm_rd_latch_q <= 1'b0;
         dm_wr_q       <= 1'b0;
         alu_write_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ir_q          <= ir_d;
         jc_q          <= jc_d;
         halted_q      <= halted_d;
         illegal_q     <= illegal_d;
         ld_inst_q     <= ld_inst_d;
         sel_q         <= sel_d;
         dm_rd_q       <= dm_rd_d;
         dm_rd_latch_q <= dm_rd_latch_d;
         dm_wr_q       <= dm_wr_d;
         alu_write_q   <= alu_write_d;
      end
   end

   // Next state, pc/IR update, and the outputs of the state being entered.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ir_d          = ir_q;
      jc_d          = jc_q;
      halted_d      = halted_q;
      illegal_d     = illegal_q;
      ld_inst_d     = 1'b0;
      sel_d         = SEL_VAL;
      dm_rd_d       = 1'b0;
      dm_rd_latch_d = 1'b0;
      dm_wr_d       = 1'b0;
      alu_write_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            ir_d    = instruction[15:13];
            state_d = S_EXEC1;
         end
         S_EXEC1: begin
            case (ir_q)
               OP_MOV, OP_ALU: begin
                  state_d = S_EXEC2;
               end
               OP_JMP: begin
                  pc_d    = pc_inc;
                  state_d = S_EXEC2;
               end
               OP_JC: begin
                  pc_d    = pc_inc;
                  jc_d    = jump_cond;
                  state_d = S_EXEC2;
               end
               OP_HLT: begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end
               OP_ILL: begin
                  illegal_d = 1'b1;
                  pc_d      = pc_inc;
                  state_d   = S_FETCH;
               end
               default: begin
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_EXEC2: begin
            state_d = S_FETCH;
            case (ir_q)
               OP_JMP:  pc_d = addbus;
               // A not-taken branch steps over its address word.
               OP_JC:   pc_d = jc_q ? addbus : pc_inc;
               default: pc_d = pc_inc;
            endcase
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case (state_d)
         S_DECODE: begin
            ld_inst_d = 1'b1;
         end
         S_EXEC1: begin
            ld_inst_d = 1'b1;
            case (ir_d)
               OP_LDI: dm_wr_d = 1'b1;
               OP_MOV: begin
                  sel_d         = SEL_REG1;
                  dm_rd_d       = 1'b1;
                  dm_rd_latch_d = 1'b1;
               end
               OP_ALU: begin
                  sel_d   = SEL_REG3;
                  dm_rd_d = 1'b1;
               end
               default: sel_d = SEL_VAL;
            endcase
         end
         S_EXEC2: begin
            ld_inst_d = 1'b1;
            case (ir_d)
               OP_MOV: begin
                  sel_d   = SEL_REG2;
                  dm_wr_d = 1'b1;
               end
               OP_ALU: begin
                  sel_d       = SEL_REG3;
                  alu_write_d = 1'b1;
               end
               OP_JMP, OP_JC: sel_d = SEL_ADDR;
               default: sel_d = SEL_VAL;
            endcase
         end
         default: ld_inst_d = 1'b0;
      endcase
   end

   assign pc          = pc_q;
   assign ld_inst     = ld_inst_q;
   assign ld_val_reg  = sel_q;
   assign dm_rd       = dm_rd_q;
   assign dm_rd_latch = dm_rd_latch_q;
   assign dm_wr       = dm_wr_q;
   assign alu_write   = alu_write_q;
   assign halted      = halted_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a cycle table for a straight-line program,
// then hand sequences for jump wrap, illegal/halt and reset mid-instruction.
module tb_fetch_seq;

   logic        clk = 1'b0;
   logic        clr, run, jump_cond;
   logic [15:0] instruction, addbus, pc;
   logic        ld_inst, dm_rd, dm_rd_latch, dm_wr, alu_write, halted, illegal;
   logic [2:0]  ld_val_reg;

   logic [15:0] pm [0:65535];
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        clr, run, jc;
      logic [15:0] pc;
      logic        ld;
      logic [2:0]  sel;
      logic        rd, lat, wr, alu;
   } vec_t;
   vec_t vecs[$];

   assign instruction = pm[pc];
   assign addbus      = pm[pc];

   always #5 clk = ~clk;

   fetch_seq #(.PC_RESET(16'h0000)) dut (
      .clk(clk), .clr(clr), .run(run), .instruction(instruction),
      .addbus(addbus), .jump_cond(jump_cond), .pc(pc), .ld_inst(ld_inst),
      .ld_val_reg(ld_val_reg), .dm_rd(dm_rd), .dm_rd_latch(dm_rd_latch),
      .dm_wr(dm_wr), .alu_write(alu_write), .halted(halted), .illegal(illegal)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic c, input logic r, input logic j);
      @(negedge clk);
      clr = c; run = r; jump_cond = j;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string name, input logic [15:0] p, input logic ld,
                             input logic [2:0] s, input logic rd, input logic lat,
                             input logic wr, input logic alu, input logic h, input logic ill);
      check({name, ".pc"}, 32'(pc), 32'(p));
      check({name, ".ld_inst"}, 32'(ld_inst), 32'(ld));
      check({name, ".ld_val_reg"}, 32'(ld_val_reg), 32'(s));
      check({name, ".dm_rd"}, 32'(dm_rd), 32'(rd));
      check({name, ".dm_rd_latch"}, 32'(dm_rd_latch), 32'(lat));
      check({name, ".dm_wr"}, 32'(dm_wr), 32'(wr));
      check({name, ".alu_write"}, 32'(alu_write), 32'(alu));
      check({name, ".halted"}, 32'(halted), 32'(h));
      check({name, ".illegal"}, 32'(illegal), 32'(ill));
   endtask

   task automatic add(input logic c, input logic r, input logic j, input logic [15:0] p,
                      input logic ld, input logic [2:0] s, input logic rd, input logic lat,
                      input logic wr, input logic alu);
      vec_t v;
      v.clr = c; v.run = r; v.jc = j; v.pc = p; v.ld = ld; v.sel = s;
      v.rd = rd; v.lat = lat; v.wr = wr; v.alu = alu;
      vecs.push_back(v);
   endtask

   // Decode/exec/fetch rows of a single-cycle NOP at address p.
   task automatic add_nop(input logic [15:0] p);
      add(0, 0, 0, p, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0, p, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0, p + 16'd1, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      clr = 1'b1; run = 1'b0; jump_cond = 1'b0;
      for (int i = 0; i < 65536; i++) pm[i] = 16'h0000;
      pm[0]     = 16'h2000;  // LDI
      pm[4]     = 16'h4000;  // MOV
      pm[5]     = 16'h6000;  // ALU
      pm[8]     = 16'hA000;  // JC -> 0x40 (taken)
      pm[9]     = 16'h0040;
      pm[16'h40] = 16'hA000; // JC (not taken)
      pm[16'h41] = 16'h0100;

      //   clr run jc pc       ld sel rd lat wr alu
      add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);  // reset
      add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);  // idle holds
      add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);  // fetch
      add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0);  // decode LDI
      add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 0);  // exec1 LDI
      add(0, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 0);  // fetch pc=1
      for (int p = 1; p <= 3; p++) add_nop(16'(p));
      add(0, 0, 0, 16'h0004, 1, 0, 0, 0, 0, 0);  // decode MOV
      add(0, 0, 0, 16'h0004, 1, 1, 1, 1, 0, 0);  // exec1 MOV
      add(0, 0, 0, 16'h0004, 1, 2, 0, 0, 1, 0);  // exec2 MOV
      add(0, 0, 0, 16'h0005, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 16'h0005, 1, 0, 0, 0, 0, 0);  // decode ALU
      add(0, 0, 0, 16'h0005, 1, 3, 1, 0, 0, 0);  // exec1 ALU
      add(0, 0, 0, 16'h0005, 1, 3, 0, 0, 0, 1);  // exec2 ALU
      add(0, 0, 0, 16'h0006, 0, 0, 0, 0, 0, 0);
      for (int p = 6; p <= 7; p++) add_nop(16'(p));
      add(0, 0, 0, 16'h0008, 1, 0, 0, 0, 0, 0);  // decode JC
      add(0, 0, 0, 16'h0008, 1, 0, 0, 0, 0, 0);  // exec1 JC
      add(0, 0, 1, 16'h0009, 1, 5, 0, 0, 0, 0);  // exec2, cond=1 sampled
      add(0, 0, 0, 16'h0040, 0, 0, 0, 0, 0, 0);  // taken
      add(0, 0, 0, 16'h0040, 1, 0, 0, 0, 0, 0);  // decode JC
      add(0, 0, 1, 16'h0040, 1, 0, 0, 0, 0, 0);  // exec1 (cond not yet sampled)
      add(0, 0, 0, 16'h0041, 1, 5, 0, 0, 0, 0);  // exec2, cond=0 sampled
      add(0, 0, 0, 16'h0042, 0, 0, 0, 0, 0, 0);  // skipped address word

      foreach (vecs[i]) begin
         cyc(vecs[i].clr, vecs[i].run, vecs[i].jc);
         expect_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ld, vecs[i].sel,
                    vecs[i].rd, vecs[i].lat, vecs[i].wr, vecs[i].alu, 1'b0, 1'b0);
      end

      // JMP to 0xFFFF, then JMP at 0xFFFF whose address word wraps to 0.
      pm[16'h42]   = 16'h8000;
      pm[16'h43]   = 16'hFFFF;
      pm[16'hFFFF] = 16'h8000;
      pm[0]        = 16'h0003;
      pm[3]        = 16'hE000;  // illegal
      pm[4]        = 16'hC000;  // HLT
      cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      expect_all("jmp_exec2", 16'h0043, 1, 5, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0);
      expect_all("jmp_to_ffff", 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      expect_all("wrap_exec2", 16'h0000, 1, 5, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0);
      expect_all("wrap_target", 16'h0003, 0, 0, 0, 0, 0, 0, 0, 0);

      // Illegal opcode then HLT.
      cyc(0, 0, 0); cyc(0, 0, 0);
      expect_all("ill_exec1", 16'h0003, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0);
      expect_all("ill_sticky", 16'h0004, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0); cyc(0, 0, 0);
      expect_all("hlt_exec1", 16'h0004, 1, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0);
      expect_all("halt", 16'h0004, 0, 0, 0, 0, 0, 0, 1, 1);
      for (int k = 0; k < 6; k++) begin
         cyc(0, 1'(k % 2), 0);
         expect_all($sformatf("halt_hold%0d", k), 16'h0004, 0, 0, 0, 0, 0, 0, 1, 1);
      end
      cyc(1, 1, 0);
      expect_all("halt_clr", 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0);
      expect_all("idle_after_clr", 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset during EXEC1 of MOV: the EXEC2 write must never happen.
      pm[0] = 16'h4000;
      cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      expect_all("mov_exec1", 16'h0000, 1, 1, 1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0);
      expect_all("mov_clr", 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0);
         expect_all($sformatf("mov_clr_idle%0d", k), 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      // Restart from IDLE: FETCH then DECODE.
      cyc(0, 1, 0);
      expect_all("restart_fetch", 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0);
      expect_all("restart_decode", 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
